// File: rtl/pll_reset_pkg.sv
// Shared state encoding and default timing constants for the PLL reset sequencer.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int DEF_LOCK_STABLE_CYCLES = 16;
  localparam int DEF_RST_HOLD_CYCLES    = 32;
  localparam int DEF_LOSS_CNT_W         = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser with synchronous reset; used for any async level input.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// Qualifies PLL lock, holds the core in reset for a fixed interval, then issues
// 4 MHz / 1 MHz clock enables from the 8 MHz clock and counts lock losses.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
  parameter int LOSS_CNT_W         = DEF_LOSS_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  soft_rst,
  output logic                  core_reset,
  output logic                  ce_4m,
  output logic                  ce_1m,
  output logic                  running,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int CNT_W = $clog2(max2(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES));
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);

  logic                  lock_s;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            div_q, div_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d, loss_inc;

  sync_2ff u_lock_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (pll_locked),
    .sync_out (lock_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      div_q   <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      loss_q  <= loss_d;
    end
  end

  // Saturates at all-ones; only reset clears it.
  assign loss_inc = (loss_q == '1) ? loss_q : loss_q + LOSS_CNT_W'(1);

  // Priority in every qualified state: lock loss, then soft_rst, then counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    loss_d  = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!lock_s) state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          loss_d  = loss_inc;
        end else if (soft_rst) cnt_d = '0;
        else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          div_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          loss_d  = loss_inc;
        end else if (soft_rst) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else div_d = div_q + 3'd1;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_comb begin
    running    = (state_q == RUN);
    core_reset = !running;
    ce_4m      = running & div_q[0];
    ce_1m      = running & (div_q == 3'd7);
  end

  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench: stimulus pushes expected outputs tagged with an edge number,
// a negedge monitor pops and compares them when that edge has been reached.
module tb_pll_reset_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b1;
  logic       soft_rst = 1'b0;
  logic       core_reset, ce_4m, ce_1m, running;
  logic [7:0] lock_loss_cnt;

  int edge_cnt = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int   at;
    logic cr, c4, c1, run;
    int   loss;
    int   scn;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  pll_reset_seq dut (
    .clk           (clk),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .soft_rst      (soft_rst),
    .core_reset    (core_reset),
    .ce_4m         (ce_4m),
    .ce_1m         (ce_1m),
    .running       (running),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
      e = sb.pop_front();
      checks++;
      if (e.at != edge_cnt) begin
        failures++;
        $display("FAIL s%0d_e%0d: expectation missed, now at edge %0d", e.scn, e.at, edge_cnt);
      end else if (core_reset !== e.cr || ce_4m !== e.c4 || ce_1m !== e.c1 ||
                   running !== e.run || int'(lock_loss_cnt) != e.loss) begin
        failures++;
        $display("FAIL s%0d_e%0d: got cr=%b ce4=%b ce1=%b run=%b loss=%0d, want cr=%b ce4=%b ce1=%b run=%b loss=%0d",
                 e.scn, e.at, core_reset, ce_4m, ce_1m, running, lock_loss_cnt,
                 e.cr, e.c4, e.c1, e.run, e.loss);
      end
    end
  end

  task automatic expect_at(input int at, input logic cr, input logic c4, input logic c1,
                           input logic run, input int loss, input int scn);
    exp_t x;
    x.at = at; x.cr = cr; x.c4 = c4; x.c1 = c1; x.run = run; x.loss = loss; x.scn = scn;
    sb.push_back(x);
  endtask

  task automatic wait_to(input int t);
    while (edge_cnt < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset held for ncyc edges; base is the first edge with reset low ("edge 0").
  task automatic do_reset(input int ncyc, input logic lk, input int scn, output int base);
    int c;
    c = edge_cnt;
    reset = 1'b1;
    pll_locked = lk;
    expect_at(c + 1, 1, 0, 0, 0, 0, scn);
    wait_to(c + ncyc);
    reset = 1'b0;
    base = c + ncyc + 1;
  endtask

  task automatic check_boot(input int b, input int scn);
    expect_at(b + 17, 1, 0, 0, 0, 0, scn);
    expect_at(b + 49, 1, 0, 0, 0, 0, scn);
    expect_at(b + 50, 0, 0, 0, 1, 0, scn);
    expect_at(b + 51, 0, 1, 0, 1, 0, scn);
    expect_at(b + 52, 0, 0, 0, 1, 0, scn);
    expect_at(b + 56, 0, 0, 0, 1, 0, scn);
    expect_at(b + 57, 0, 1, 1, 1, 0, scn);
    expect_at(b + 58, 0, 0, 0, 1, 0, scn);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int base, b2, x;
    @(posedge clk);
    #1;

    // 1: boot with lock steady
    do_reset(3, 1'b1, 1, base);
    check_boot(base, 1);
    wait_to(base + 58);

    // 2: one-cycle lock drop in RUN, then full requalification
    b2 = edge_cnt;
    expect_at(b2 + 2,  0, 0, 0, 1, 0, 2);
    expect_at(b2 + 3,  1, 0, 0, 0, 1, 2);
    expect_at(b2 + 51, 1, 0, 0, 0, 1, 2);
    expect_at(b2 + 52, 0, 0, 0, 1, 1, 2);
    expect_at(b2 + 53, 0, 1, 0, 1, 1, 2);
    pll_locked = 1'b0;
    wait_to(b2 + 1);
    pll_locked = 1'b1;
    wait_to(b2 + 53);

    // 3: lock toggling every 10 cycles never qualifies
    do_reset(2, 1'b1, 3, base);
    for (int i = 0; i < 10; i++) begin
      expect_at(base + 10*i + 5, 1, 0, 0, 0, 0, 3);
      wait_to(base + 10*i + 9);
      pll_locked = ~pll_locked;
    end
    wait_to(base + 100);

    // 4: soft_rst in RUN, then a second one at HOLD cycle 20
    do_reset(2, 1'b1, 4, base);
    expect_at(base + 50,  0, 0, 0, 1, 0, 4);
    expect_at(base + 60,  0, 0, 0, 1, 0, 4);
    expect_at(base + 61,  1, 0, 0, 0, 0, 4);
    expect_at(base + 92,  1, 0, 0, 0, 0, 4);
    expect_at(base + 93,  0, 0, 0, 1, 0, 4);
    expect_at(base + 94,  0, 1, 0, 1, 0, 4);
    expect_at(base + 100, 0, 1, 1, 1, 0, 4);
    expect_at(base + 101, 1, 0, 0, 0, 0, 4);
    expect_at(base + 121, 1, 0, 0, 0, 0, 4);
    expect_at(base + 133, 1, 0, 0, 0, 0, 4);
    expect_at(base + 152, 1, 0, 0, 0, 0, 4);
    expect_at(base + 153, 0, 0, 0, 1, 0, 4);
    expect_at(base + 154, 0, 1, 0, 1, 0, 4);
    wait_to(base + 60);  soft_rst = 1'b1;
    wait_to(base + 61);  soft_rst = 1'b0;
    wait_to(base + 100); soft_rst = 1'b1;
    wait_to(base + 101); soft_rst = 1'b0;
    wait_to(base + 120); soft_rst = 1'b1;
    wait_to(base + 121); soft_rst = 1'b0;
    wait_to(base + 155);

    // 6: one-cycle reset mid-RUN (div would have produced ce_4m), timing repeats
    do_reset(1, 1'b1, 6, base);
    check_boot(base, 6);
    wait_to(base + 58);

    // 5: 300 qualified lock losses saturate the counter
    for (int i = 0; i < 300; i++) begin
      x = edge_cnt;
      expect_at(x + 52, 0, 0, 0, 1, (i + 1 > 255) ? 255 : i + 1, 5);
      pll_locked = 1'b0;
      wait_to(x + 1);
      pll_locked = 1'b1;
      wait_to(x + 53);
    end
    x = edge_cnt;
    expect_at(x + 10, 0, 1, 0, 1, 255, 5);
    wait_to(x + 12);

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations never reached", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Sits directly downstream of the system PLL (8 MHz / 4 MHz outputs plus `locked`). Runs in the 8 MHz domain.
- Synchronises the asynchronous PLL `locked` flag and requires it to stay stable before releasing the core.
- Holds the game core in reset for a fixed interval after lock, then generates 4 MHz and 1 MHz clock enables for the core.
- Counts lock-loss events for the debug OSD.

Parameters:
- LOCK_STABLE_CYCLES, 16, consecutive synchronised-lock cycles required before the reset hold starts (≥2).
- RST_HOLD_CYCLES, 32, cycles `core_reset` stays asserted after lock is qualified (≥2).
- LOSS_CNT_W, 8, width of the saturating lock-loss counter.

Ports:
- clk  in  1  8 MHz system clock (PLL outclk_0).
- reset  in  1  synchronous, active-high; from the framework/user.
- pll_locked  in  1  PLL locked; asynchronous to clk.
- soft_rst  in  1  single-cycle core reset request; synchronous.
- core_reset  out  1  active-high reset to the game core.
- ce_4m  out  1  4 MHz clock enable; 1 of every 2 clk cycles.
- ce_1m  out  1  1 MHz clock enable; 1 of every 8 clk cycles.
- running  out  1  high in RUN state.
- lock_loss_cnt  out  LOSS_CNT_W  saturating count of lock losses since reset.

Behaviour:
- Only one clock is used. Reset is synchronous and active-high; the ports are named `clk` and `reset`.
- On reset:
  - state = WAIT_LOCK
  - both synchroniser flops = 0
  - cnt = 0, div = 0
  - core_reset = 1, ce_4m = 0, ce_1m = 0, running = 0
  - lock_loss_cnt = 0
- `lock_s` is `pll_locked` passed through a 2-flop synchroniser, giving 2 cycles of latency.
- States and transitions, evaluated every clk edge:
  - WAIT_LOCK: if lock_s = 1, go to STABLE and set cnt = 0.
  - STABLE:
    - If lock_s = 0, go to WAIT_LOCK.
    - Otherwise, if cnt = LOCK_STABLE_CYCLES-1, go to HOLD and set cnt = 0.
    - Otherwise, cnt++.
  - HOLD:
    - If lock_s = 0, go to WAIT_LOCK and increment lock_loss_cnt.
    - Otherwise, if soft_rst = 1, set cnt = 0 and re-arm the hold.
    - Otherwise, if cnt = RST_HOLD_CYCLES-1, go to RUN and set div = 0.
    - Otherwise, cnt++.
  - RUN:
    - If lock_s = 0, go to WAIT_LOCK and increment lock_loss_cnt.
    - Otherwise, if soft_rst = 1, go to HOLD and set cnt = 0.
    - Otherwise, div++ (3-bit, wraps 7→0).
- Priority: lock loss > soft_rst > counting.
- soft_rst is ignored in WAIT_LOCK and STABLE.
- Outputs are decoded from registered state:
  - core_reset = (state != RUN).
  - running = (state == RUN).
  - ce_4m = running & div[0].
  - ce_1m = running & (div == 7).
- On the first RUN cycle div = 0, so there are no enables in that cycle. The first ce_4m comes on the 2nd RUN cycle and the first ce_1m on the 8th.
- A lock loss in STABLE does not increment lock_loss_cnt; only losses after qualification count.
- lock_loss_cnt saturates at all-ones and is cleared only by reset.
- Reset mid-operation (any state) returns to the full reset values on the next edge. No enable pulse may be emitted in that cycle.
- cnt width is $clog2(max(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES)).

Decomposition:
- Shared package `pll_reset_pkg` holds:
  - state encoding: WAIT_LOCK = 2'd0, STABLE = 2'd1, HOLD = 2'd2, RUN = 2'd3
  - default parameter constants
- One sub-module, `sync_2ff`: a 1-bit two-flop synchroniser with synchronous reset. It is reused for other async inputs.

Test Plan:
1. Reset released at edge 0 with pll_locked = 1 constant (defaults):
   - lock_s rises after edge 1; STABLE entered at edge 2; HOLD at edge 18; RUN at edge 50.
   - core_reset falls after edge 50; first ce_4m after edge 51; first ce_1m after edge 57.
2. In RUN, pll_locked dropped for 1 cycle:
   - core_reset rises 3 edges later; lock_loss_cnt = 1; enables stop the same cycle.
   - Full 16+32 requalification follows before running returns to 1.
3. pll_locked toggles every 10 cycles after reset:
   - The core never leaves STABLE; core_reset stays 1; lock_loss_cnt stays 0.
4. soft_rst pulsed in RUN:
   - core_reset = 1 for exactly 32 cycles, then RUN with div restarting at 0.
   - A second soft_rst at HOLD cycle 20 extends the total to 52 cycles.
5. 300 lock-loss events, each after RUN is reached: lock_loss_cnt reads 255 and stays at 255.
6. reset asserted for 1 cycle mid-RUN with pll_locked = 1: all outputs return to reset values, and the scenario-1 timing repeats exactly.
